// File: rtl/n64_demux_ctrl.sv
// n64_demux_ctrl
// Sequencing and configuration controller for the N64 video demultiplexer.
// Tracks the nDSYNC phase, drives the colour-slot counter, measures lines per
// field from the sync nibble, classifies PAL/NTSC and 240p/480i, and applies
// user settings only at field boundaries so a frame never mixes configurations.

`timescale 1ns/1ps

module n64_demux_ctrl (
    input  logic       VCLK,
    input  logic       RST,
    input  logic       nDSYNC,
    input  logic [6:0] D_i,
    input  logic       deblur_en_i,
    input  logic       n15bit_i,
    input  logic [3:0] gamma_i,
    output logic [4:0] demuxparams_o,
    output logic [3:0] gammaparams_o,
    output logic       vmode_o,
    output logic       n64_480i_o,
    output logic [9:0] field_lines_o
);

    localparam logic [3:0] GAMMA_OFF  = 4'd5;
    localparam logic [9:0] PAL_THRESH = 10'd288;
    localparam logic [9:0] LINE_MAX   = 10'd1023;

    // How much field history has been collected since reset: the field in
    // progress at reset is partial and must never be compared against.
    typedef enum logic [1:0] {
        HIST_EMPTY,
        HIST_ALIGNED,
        HIST_ONE
    } hist_state_t;

    hist_state_t hist_state;
    hist_state_t hist_next;

    logic [1:0] data_cnt;
    logic [3:0] sync_prev;
    logic [9:0] line_cnt;
    logic [9:0] line_inc;
    logic [9:0] field_count;
    logic [9:0] prev_lines;
    logic       hs_fall;
    logic       vs_fall;
    logic       cur_pal;
    logic       prev_pal;
    logic       vmode_next;
    logic       i480_next;
    logic       deblur_latched;
    logic       ndo_deblur;
    logic       n15bit_mode;
    logic       unused_bits;

    // Pixel data bits and the clamp/csync history belong to the demux datapath.
    assign unused_bits = ^{D_i[6:4], sync_prev[2], sync_prev[0]};

    // Sync edges only exist in nDSYNC-low cycles; data cycles are ignored.
    assign hs_fall = ~nDSYNC & sync_prev[1] & ~D_i[1];
    assign vs_fall = ~nDSYNC & sync_prev[3] & ~D_i[3];

    // A line ending together with vsync still belongs to the closing field.
    assign line_inc    = (line_cnt == LINE_MAX) ? LINE_MAX : line_cnt + 10'd1;
    assign field_count = hs_fall ? line_inc : line_cnt;

    assign cur_pal  = (field_count >= PAL_THRESH);
    assign prev_pal = (prev_lines >= PAL_THRESH);

    // Slot counter: load on the sync cycle, count through the three data slots, park at zero.
    always_ff @(posedge VCLK or posedge RST) begin
        if (RST) begin
            data_cnt <= 2'b00;
        end else if (!nDSYNC) begin
            data_cnt <= 2'b01;
        end else if (data_cnt != 2'b00) begin
            data_cnt <= data_cnt + 2'b01;
        end
    end

    // Remember the last sync nibble and count hsync falls within the current field.
    always_ff @(posedge VCLK or posedge RST) begin
        if (RST) begin
            sync_prev <= 4'hF;
            line_cnt  <= 10'd0;
        end else begin
            if (!nDSYNC) begin
                sync_prev <= D_i[3:0];
            end
            if (vs_fall) begin
                line_cnt <= 10'd0;
            end else if (hs_fall) begin
                line_cnt <= line_inc;
            end
        end
    end

    // History state register.
    always_ff @(posedge VCLK or posedge RST) begin
        if (RST) begin
            hist_state <= HIST_EMPTY;
        end else begin
            hist_state <= hist_next;
        end
    end

    // Decide history progress and the next vmode / 480i status at each field end.
    always_comb begin
        hist_next  = hist_state;
        vmode_next = vmode_o;
        i480_next  = n64_480i_o;
        if (vs_fall) begin
            case (hist_state)
                HIST_EMPTY: begin
                    hist_next = HIST_ALIGNED;
                end
                HIST_ALIGNED: begin
                    hist_next = HIST_ONE;
                end
                HIST_ONE: begin
                    i480_next = (field_count != prev_lines);
                    if (cur_pal == prev_pal) begin
                        vmode_next = cur_pal;
                    end
                end
                default: begin
                    hist_next = HIST_EMPTY;
                end
            endcase
        end
    end

    // Publish field measurements and keep the previous full field for comparison.
    always_ff @(posedge VCLK or posedge RST) begin
        if (RST) begin
            field_lines_o <= 10'd0;
            vmode_o       <= 1'b0;
            n64_480i_o    <= 1'b0;
            prev_lines    <= 10'd0;
        end else if (vs_fall) begin
            field_lines_o <= field_count;
            vmode_o       <= vmode_next;
            n64_480i_o    <= i480_next;
            if (hist_state != HIST_EMPTY) begin
                prev_lines <= field_count;
            end
        end
    end

    // Shadow the user settings so they only take effect on a field boundary.
    always_ff @(posedge VCLK or posedge RST) begin
        if (RST) begin
            n15bit_mode    <= 1'b1;
            gammaparams_o  <= GAMMA_OFF;
            deblur_latched <= 1'b0;
        end else if (vs_fall) begin
            n15bit_mode    <= n15bit_i;
            gammaparams_o  <= gamma_i;
            deblur_latched <= deblur_en_i;
        end
    end

    // Deblur is forced off for interlaced sources; lags a cycle to see the new 480i status.
    always_ff @(posedge VCLK or posedge RST) begin
        if (RST) begin
            ndo_deblur <= 1'b1;
        end else begin
            ndo_deblur <= ~deblur_latched | n64_480i_o;
        end
    end

    assign demuxparams_o = {data_cnt, vmode_o, ndo_deblur, n15bit_mode};

endmodule

// File: tb/tb_n64_demux_ctrl.sv
// tb_n64_demux_ctrl
// Directed stimulus for n64_demux_ctrl. Stimulus pushes hand-computed
// expectations tagged with a clock cycle; a separate monitor pops and compares
// them on the falling edge of that cycle.

`timescale 1ns/1ps

module tb_n64_demux_ctrl;

    localparam int S_CNT   = 0;
    localparam int S_VMODE = 1;
    localparam int S_NDO   = 2;
    localparam int S_N15   = 3;
    localparam int S_GAMMA = 4;
    localparam int S_480I  = 5;
    localparam int S_LINES = 6;
    localparam int S_VDUP  = 7;

    logic       VCLK = 1'b0;
    logic       RST;
    logic       nDSYNC;
    logic [6:0] D_i;
    logic       deblur_en_i;
    logic       n15bit_i;
    logic [3:0] gamma_i;
    logic [4:0] demuxparams_o;
    logic [3:0] gammaparams_o;
    logic       vmode_o;
    logic       n64_480i_o;
    logic [9:0] field_lines_o;

    typedef struct {
        int    cycle;
        int    sel;
        string name;
        int    value;
    } exp_t;

    typedef struct {
        int sent;
        int lines;
        int vm;
        int i480;
        int ndo_old;
        int ndo_new;
        int gam;
        int n15;
    } field_t;

    exp_t sb_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    n64_demux_ctrl dut (
        .VCLK          (VCLK),
        .RST           (RST),
        .nDSYNC        (nDSYNC),
        .D_i           (D_i),
        .deblur_en_i   (deblur_en_i),
        .n15bit_i      (n15bit_i),
        .gamma_i       (gamma_i),
        .demuxparams_o (demuxparams_o),
        .gammaparams_o (gammaparams_o),
        .vmode_o       (vmode_o),
        .n64_480i_o    (n64_480i_o),
        .field_lines_o (field_lines_o)
    );

    // Free-running video clock.
    always #5 VCLK = ~VCLK;

    // Cycle index shared by stimulus and monitor.
    always @(posedge VCLK) cyc++;

    function automatic int get_out(input int sel);
        case (sel)
            S_CNT:   return int'(demuxparams_o[4:3]);
            S_VMODE: return int'(vmode_o);
            S_NDO:   return int'(demuxparams_o[1]);
            S_N15:   return int'(demuxparams_o[0]);
            S_GAMMA: return int'(gammaparams_o);
            S_480I:  return int'(n64_480i_o);
            S_LINES: return int'(field_lines_o);
            S_VDUP:  return int'(demuxparams_o[2]);
            default: return -1;
        endcase
    endfunction

    task automatic check_output(input exp_t e);
        int actual;
        actual = get_out(e.sel);
        checks++;
        if (actual != e.value) begin
            errors++;
            $display("[TB] FAIL %s @cycle %0d: got %0d, expected %0d", e.name, e.cycle, actual, e.value);
        end
    endtask

    // Monitor: compare every expectation scheduled for the cycle that just ended.
    always @(negedge VCLK) begin : monitor
        int idx;
        idx = 0;
        while (idx < sb_q.size()) begin
            if (sb_q[idx].cycle == cyc) begin
                check_output(sb_q[idx]);
                sb_q.delete(idx);
            end else if (sb_q[idx].cycle < cyc) begin
                checks++;
                errors++;
                $display("[TB] FAIL %s: expectation for cycle %0d never compared (now %0d)", sb_q[idx].name, sb_q[idx].cycle, cyc);
                sb_q.delete(idx);
            end else begin
                idx++;
            end
        end
    end

    task automatic expect_at(input int offset, input int sel, input string name, input int value);
        exp_t e;
        e.cycle = cyc + offset;
        e.sel   = sel;
        e.name  = name;
        e.value = value;
        sb_q.push_back(e);
    endtask

    task automatic apply_stimulus(input logic nd, input logic [3:0] sync);
        nDSYNC = nd;
        D_i    = {3'b000, sync};
        @(posedge VCLK);
        #1;
    endtask

    task automatic send_lines(input int n);
        for (int i = 0; i < n; i++) begin
            apply_stimulus(1'b0, 4'b1101);
            apply_stimulus(1'b0, 4'b1111);
        end
    endtask

    task automatic end_field(input logic [3:0] vs_nibble, input int lines, input int vm,
                             input int i480, input int ndo_old, input int ndo_new,
                             input int gam, input int n15);
        apply_stimulus(1'b0, vs_nibble);
        expect_at(0, S_LINES, "field_lines", lines);
        expect_at(0, S_VMODE, "vmode", vm);
        expect_at(0, S_VDUP,  "demux_vmode", vm);
        expect_at(0, S_480I,  "n64_480i", i480);
        expect_at(0, S_GAMMA, "gamma_latch", gam);
        expect_at(0, S_N15,   "n15bit_latch", n15);
        expect_at(0, S_NDO,   "ndo_deblur_before", ndo_old);
        expect_at(1, S_NDO,   "ndo_deblur_after", ndo_new);
        apply_stimulus(1'b0, 4'b1111);
    endtask

    task automatic run_field(input field_t f);
        send_lines(f.sent);
        end_field(4'b0111, f.lines, f.vm, f.i480, f.ndo_old, f.ndo_new, f.gam, f.n15);
    endtask

    task automatic check_reset_values();
        expect_at(0, S_CNT,   "rst_data_cnt", 0);
        expect_at(0, S_VMODE, "rst_vmode", 0);
        expect_at(0, S_480I,  "rst_480i", 0);
        expect_at(0, S_LINES, "rst_field_lines", 0);
        expect_at(0, S_NDO,   "rst_ndo_deblur", 1);
        expect_at(0, S_N15,   "rst_n15bit", 1);
        expect_at(0, S_GAMMA, "rst_gamma", 5);
    endtask

    logic   slot_nd [14] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
                             1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int     slot_ex [14] = '{1, 2, 3, 0, 1, 2, 3, 1, 2, 3, 0, 0, 0, 1};

    field_t pal_tab [14] = '{
        '{50,  50,  0, 0, 1, 0, 5, 1},
        '{263, 263, 0, 0, 0, 0, 5, 1},
        '{263, 263, 0, 0, 0, 0, 5, 1},
        '{263, 263, 0, 0, 0, 0, 5, 1},
        '{263, 263, 0, 0, 0, 0, 5, 1},
        '{313, 313, 0, 1, 0, 1, 5, 1},
        '{263, 263, 0, 1, 1, 1, 5, 1},
        '{263, 263, 0, 0, 1, 0, 5, 1},
        '{313, 313, 0, 1, 0, 1, 5, 1},
        '{313, 313, 1, 0, 1, 0, 5, 1},
        '{287, 287, 1, 1, 0, 1, 5, 1},
        '{287, 287, 0, 0, 1, 0, 5, 1},
        '{288, 288, 0, 1, 0, 1, 5, 1},
        '{288, 288, 1, 0, 1, 0, 5, 1}
    };

    field_t i480_tab [6] = '{
        '{30,   30,   0, 0, 1, 0, 7, 1},
        '{262,  262,  0, 0, 0, 0, 7, 1},
        '{263,  263,  0, 1, 0, 1, 7, 1},
        '{262,  262,  0, 1, 1, 1, 7, 1},
        '{263,  263,  0, 1, 1, 1, 7, 1},
        '{1030, 1023, 0, 1, 1, 1, 7, 1}
    };

    // Directed test sequence.
    initial begin
        RST         = 1'b1;
        nDSYNC      = 1'b1;
        D_i         = 7'h0F;
        deblur_en_i = 1'b0;
        n15bit_i    = 1'b1;
        gamma_i     = 4'd5;

        apply_stimulus(1'b1, 4'hF);
        apply_stimulus(1'b1, 4'hF);
        check_reset_values();
        RST = 1'b0;

        $display("[TB] slot counter");
        for (int i = 0; i < 14; i++) begin
            apply_stimulus(slot_nd[i], slot_nd[i] ? 4'h0 : 4'hF);
            expect_at(0, S_CNT, "data_cnt", slot_ex[i]);
        end
        expect_at(0, S_LINES, "no_events_in_data_cycles", 0);

        $display("[TB] NTSC 240p, PAL switch and threshold");
        deblur_en_i = 1'b1;
        for (int i = 0; i < 14; i++) begin
            run_field(pal_tab[i]);
        end

        $display("[TB] deferred config");
        send_lines(40);
        gamma_i     = 4'd2;
        n15bit_i    = 1'b0;
        deblur_en_i = 1'b0;
        send_lines(1);
        expect_at(0, S_GAMMA, "gamma_held", 5);
        expect_at(0, S_N15,   "n15bit_held", 1);
        expect_at(0, S_NDO,   "ndo_held", 0);
        send_lines(247);
        expect_at(0, S_GAMMA, "gamma_held_pre_vsync", 5);
        end_field(4'b0111, 288, 1, 0, 0, 1, 2, 0);

        $display("[TB] simultaneous hsync and vsync");
        send_lines(99);
        end_field(4'b0101, 100, 1, 1, 1, 1, 2, 0);
        send_lines(5);
        end_field(4'b0111, 5, 0, 1, 1, 1, 2, 0);

        $display("[TB] reset mid-field and 480i");
        gamma_i     = 4'd7;
        n15bit_i    = 1'b1;
        deblur_en_i = 1'b1;
        send_lines(100);
        RST = 1'b1;
        #1;
        check_reset_values();
        apply_stimulus(1'b0, 4'hF);
        check_reset_values();
        RST = 1'b0;
        for (int i = 0; i < 6; i++) begin
            run_field(i480_tab[i]);
        end

        repeat (4) @(negedge VCLK);
        #1;
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/n64_demux_ctrl.md
# n64_demux_ctrl

Sequencing and configuration controller for the N64 video demultiplexer. It tracks the nDSYNC phase and generates the colour-slot counter. It also decodes the sync nibble to measure lines per field, classifies PAL/NTSC and 240p/480i, and presents `demuxparams_o` / `gammaparams_o` to the demux. User settings are applied only at field boundaries, so a frame is never rendered with mixed configuration.

## Interface
- `GAMMA_OFF`, 4'd5: gamma code meaning "table bypassed"; reset value of `gammaparams_o`.
- `PAL_THRESH`, 10'd288: lines per field at or above which a field counts as PAL.
- `VCLK`  in  1  video clock; all logic on rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `nDSYNC`  in  1  low marks the sync-nibble cycle of the N64 data bus.
- `D_i`  in  7  N64 data bus. In nDSYNC-low cycles: [3]=nVSYNC, [2]=nCLAMP, [1]=nHSYNC, [0]=nCSYNC.
- `deblur_en_i`  in  1  user deblur request.
- `n15bit_i`  in  1  user colour depth (1 = full 7-bit, 0 = 5-bit).
- `gamma_i`  in  4  user gamma code.
- `demuxparams_o`  out  5  {data_cnt[1:0], vmode, ndo_deblur, n15bit_mode}.
- `gammaparams_o`  out  4  gamma code in effect.
- `vmode_o`  out  1  1 = PAL (duplicated in `demuxparams_o[2]`).
- `n64_480i_o`  out  1  1 = interlaced source detected.
- `field_lines_o`  out  10  line count of the last completed field.

## Operation
- **Slot counter `data_cnt`**
  - nDSYNC low: loads 2'b01.
  - nDSYNC high and cnt != 0: cnt+1, so 11 wraps to 00.
  - nDSYNC high and cnt == 0: holds 00 (idle; the demux takes no action).
  - A malformed bus (more than 3 high cycles) therefore parks in 00 until the next nDSYNC low.
- **Sync sampling**
  - `sync_prev[3:0]` updates only in nDSYNC-low cycles.
  - Edge events are combinational against the current `D_i[3:0]`:
    - `hs_fall` = prev[1] & ~D_i[1]
    - `vs_fall` = prev[3] & ~D_i[3]
  - Events are ignored when nDSYNC is high.
- **Line counter** (10 bit): +1 on `hs_fall`; saturates at 1023.
- **Field end (`vs_fall`)**
  - `field_lines_o` <= line counter; line counter <= 0.
  - If `hs_fall` occurs in the same cycle, the counter still clears to 0 (vsync wins). That line is counted in the field just ending, i.e. `field_lines_o` gets counter+1.
- **vmode classification**
  - A field is "PAL" when its count ≥ PAL_THRESH.
  - `vmode_o` changes only after two consecutive completed fields agree and differ from the current value (2-field hysteresis).
- **480i detection**
  - Compare the last two completed field counts.
  - `n64_480i_o` <= 1 if the counts differ, 0 if they are equal.
  - Updated on every `vs_fall` from the second field after reset onward.
- **Config latch (shadow registers), at `vs_fall` only**
  - n15bit_mode <= `n15bit_i`
  - gammaparams_o <= `gamma_i`
  - deblur request <= `deblur_en_i`
  - Between vsyncs, changes to these user inputs have no effect on the outputs.
- **ndo_deblur** = ~latched_deblur | n64_480i_o. Registered and updated on the cycle after `vs_fall`, so it reflects the new 480i status.

## Timing
- Reset values:
  - `data_cnt` 00, `vmode_o` 0, `n64_480i_o` 0, `field_lines_o` 0
  - `ndo_deblur` 1, `n15bit_mode` 1, `gammaparams_o` GAMMA_OFF
  - line counter 0, `sync_prev` 4'hF, field history empty
- All outputs are registered.
  - `data_cnt` is valid one cycle after the nDSYNC sample, giving 01,10,11 on the three cycles following an nDSYNC-low cycle.
  - `field_lines_o`, `gammaparams_o`, `n15bit_mode` and `n64_480i_o` update on the edge at which `vs_fall` is sampled.
  - `ndo_deblur` updates one cycle later.
  - `vmode_o` updates at the `vs_fall` ending the second agreeing field.
- Reset asserted mid-field: everything returns to reset values immediately (async).
  - The first `vs_fall` after release latches config but does not change `vmode_o` or `n64_480i_o`, because the partial field is discarded from the history.
  - The first full field then enters the history.
- Simultaneous nDSYNC low and a pending wrap: the load of 01 wins.

## Test plan
- **Slot counter:** nDSYNC pattern low,H,H,H repeated -> `data_cnt` 01,10,11,01... Insert 5 consecutive H -> 01,10,11,00,00, then 01 after the next low.
- **NTSC 240p:** 263 lines/field for 4 fields -> `field_lines_o`=263, `vmode_o`=0, `n64_480i_o`=0. With `deblur_en_i`=1 -> `ndo_deblur`=0.
- **PAL switch:** 263-line fields, then 313,313 -> `vmode_o` rises to 1 only at the second 313 vsync. A single 313 field between 263 fields -> `vmode_o` stays 0.
- **480i:** alternate 262/263 fields with `deblur_en_i`=1 -> `n64_480i_o`=1 from the second vsync, and `ndo_deblur`=1 one cycle after that vsync.
- **Deferred config:** change `gamma_i` 5->2 and `n15bit_i` 1->0 mid-field -> outputs unchanged until the next `vs_fall`, then 2 and 0 on that edge.
- **Reset mid-field:** assert RST at line 100 -> outputs return to reset values immediately. After release, the first vsync produces no vmode/480i change.
